// File: rtl/program_counter_if.sv
// Request/status bundle between an instruction-fetch controller (master) and
// the program counter with its return stack (slave).
interface program_counter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic             en;
    logic             jmp;
    logic             brn;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] add;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             err_ovf;
    logic             err_udf;

    modport master (
        output en, jmp, brn, call, ret, target, offset,
        input  add, level, full, empty, err_ovf, err_udf
    );

    modport slave (
        input  en, jmp, brn, call, ret, target, offset,
        output add, level, full, empty, err_ovf, err_udf
    );
endinterface

// File: rtl/program_counter.sv
// Program counter with jump, relative branch and a bounded call/return stack.
// Overflowing calls and underflowing returns fall through to PC + STEP and raise sticky flags.
module program_counter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned STEP      = 1,
    parameter int unsigned DEPTH     = 4
) (
    input logic               clk,
    input logic               reset,
    program_counter_if.slave  bus
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] add_q, add_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic             push;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] add_inc;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    pop_idx;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign add_inc  = add_q + WIDTH'(STEP);
    assign push_idx = IW'(level_q);
    assign pop_idx  = IW'(level_q - LW'(1));

    // Fixed priority: jmp > call > ret > brn > sequential increment.
    always_comb begin
        add_d   = add_inc;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        push    = 1'b0;
        if (bus.jmp) begin
            add_d = bus.target;
        end else if (bus.call) begin
            if (!full) begin
                push    = 1'b1;
                level_d = level_q + LW'(1);
                add_d   = bus.target;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (bus.ret) begin
            if (!empty) begin
                add_d   = stack_q[pop_idx];
                level_d = level_q - LW'(1);
            end else begin
                udf_d = 1'b1;
            end
        end else if (bus.brn) begin
            add_d = add_q + bus.offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_q   <= WIDTH'(RESET_VEC);
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (bus.en) begin
            add_q   <= add_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Entries above level are dead, so the stack storage needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && bus.en && push) begin
            stack_q[push_idx] <= add_inc;
        end
    end

    assign bus.add     = add_q;
    assign bus.level   = level_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.err_ovf = ovf_q;
    assign bus.err_udf = udf_q;
endmodule
